mavg_sel: RTL and testbench
===========================

// Module: mavg_sel
// PURPOSE
//   Selectable-length moving-average (boxcar) filter, N in {1,8,16,32,64,128,256}.
//   Sits directly downstream of the DDS delay-line shift register and consumes its N-sample taps.
//   Keeps a running sum, acc += x_in - tap_N, and outputs acc/N.
//   Drives the delay line's enable (sr_en) and clear (sr_clr), so the two stay in lockstep.
// PARAMETERS
//   SIG_WIDTH  16  sample/tap/output width, two's complement
//   ACC_WIDTH  SIG_WIDTH+8  running-sum width (fixed; holds 256 full-scale samples)
// PORTS
//   clk      in   1          single clock, rising edge
//   rst_n    in   1          asynchronous, active-low reset
//   in_valid in   1          input sample strobe
//   in_ready out  1          sample accepted when in_valid & in_ready (combinational)
//   x_in     in   SIG_WIDTH  input sample; also wired to the delay-line input
//   len_sel  in   3          0:N=1 (bypass) 1:8 2:16 3:32 4:64 5:128 6:256 7:treated as 6
//   tap_8..tap_256 in SIG_WIDTH each (6 ports)  delay-line outputs: sample accepted 8/16/../256 samples ago
//   sr_en    out  1          delay-line shift enable = in_valid & in_ready
//   sr_clr   out  1          delay-line clear, active-high
//   y_out    out  SIG_WIDTH  averaged output, registered
//   y_valid  out  1          one-cycle pulse per output sample
// BEHAVIOUR
//   Normalisation and reset:
//   - len_sel is normalised (7 -> 6) before any compare or decode; len_q = latched length; k = log2(N).
//   - Reset (rst_n low): state=FLUSH; acc=0, cnt=0, len_q=0, y_out=0, y_valid=0.
//   - sr_clr is 1 during reset and for the first cycle after reset.
//   FSM, Moore states FLUSH / FILL / RUN:
//   - FLUSH: sr_clr=1, in_ready=0, acc<=0, cnt<=0, len_q<=len_sel. Lasts exactly 1 cycle, then FILL.
//   - FILL: in_ready=1. Each accepted sample updates acc and increments cnt; no y_valid.
//     The accept with cnt==N-1 moves to RUN and produces the first y_valid.
//   - RUN: every accepted sample produces one y_valid.
//   - Any state except FLUSH, len_sel != len_q: in_ready=0 that same cycle, next state FLUSH.
//     A length change therefore wins over a simultaneous in_valid; that sample is not accepted.
//   Datapath, on accept:
//   - acc <= acc + sext(x_in) - sext(tap_N). Taps are sampled pre-shift in the same cycle as sr_en.
//   - y_out <= (acc_next >>> k)[SIG_WIDTH-1:0]. Latency: y_valid is high the cycle after accept.
//   - Arithmetic shift gives floor toward -inf. No overflow is possible, so no saturation.
//   - Bypass, N=1: y_out <= x_in, FILL lasts 1 sample, acc unused (held 0).
//   - No accept: acc, cnt and y_out hold; y_valid=0.
// CONFIGURATION
//   MAVG_ROUND_EN:
//   - Defined: round half up. y_out = (acc_next + 2^(k-1)) >>> k for k>0; result always fits SIG_WIDTH.
//   - Undefined: truncate (floor) as above.
//   - Bypass mode is unaffected in both cases.
// TESTING
//   1 reset, len_sel=1, 8 accepts of x=100 -> y_valid first the cycle after accept 8, y_out=100.
//   2 N=8 steady 0, then constant 800 -> successive y_out 100,200,...,800, then held at 800.
//   3 RUN at N=8, len_sel->3 with in_valid=1 -> that cycle in_ready=0, sr_clr=1 next cycle, no y_valid for 32 accepts, 32nd accept -> y_valid.
//   4 N=8 window sum=12 -> y_out=1 (trunc) / 2 (MAVG_ROUND_EN); sum=-12 -> -2 / -1.
//   5 len_sel=0, x_in=-5 accepted -> next cycle y_out=-5, y_valid=1; len_sel=7 behaves exactly as 6.
//   6 rst_n low mid-FILL with in_valid gaps -> y_out=0, y_valid=0, sr_clr=1 immediately; gaps never change acc.

Source files
------------

// File: rtl/mavg_sel.sv
// -----------------------------------------------------------------------------
// mavg_sel -- selectable-length moving-average (boxcar) filter
//
// Keeps a running sum of the last N accepted samples (acc += x_in - tap_N) and
// outputs acc/N, with N in {1,8,16,32,64,128,256}. The N-sample history lives
// in an external delay line whose shift enable (sr_en) and clear (sr_clr) are
// driven from here, so the filter and the delay line always stay in lockstep.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready input handshake; a sample is taken when both are high
//   x_in                input sample (also feeds the delay line)
//   len_sel             0:N=1 (bypass) 1:8 2:16 3:32 4:64 5:128 6:256 7:as 6
//   tap_8 .. tap_256    delay-line outputs, sample accepted N samples ago
//   sr_en, sr_clr       delay-line shift enable / synchronous clear
//   y_out, y_valid      registered average and its one-cycle strobe
//
// Configuration
//   MAVG_ROUND_EN  defined: round half up; undefined: truncate toward -inf.
// -----------------------------------------------------------------------------
module mavg_sel #(
  parameter int SIG_WIDTH = 16,
  parameter int ACC_WIDTH = SIG_WIDTH + 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [SIG_WIDTH-1:0] x_in,
  input  logic        [2:0]           len_sel,
  input  logic signed [SIG_WIDTH-1:0] tap_8,
  input  logic signed [SIG_WIDTH-1:0] tap_16,
  input  logic signed [SIG_WIDTH-1:0] tap_32,
  input  logic signed [SIG_WIDTH-1:0] tap_64,
  input  logic signed [SIG_WIDTH-1:0] tap_128,
  input  logic signed [SIG_WIDTH-1:0] tap_256,
  output logic                        sr_en,
  output logic                        sr_clr,
  output logic signed [SIG_WIDTH-1:0] y_out,
  output logic                        y_valid
);

  typedef enum logic [1:0] {FLUSH, FILL, RUN} state_t;

  state_t                        state, state_next;
  logic        [2:0]             len_norm, len_q;
  logic        [7:0]             cnt, last_cnt;
  logic        [3:0]             k;
  logic                          len_change, accept, fill_done, y_fire;
  logic signed [SIG_WIDTH-1:0]   tap_sel, y_new;
  logic signed [ACC_WIDTH-1:0]   acc, acc_next, rnd, y_full;

  // Code 7 is an alias of 6; fold it before anything compares against len_q.
  assign len_norm   = (len_sel == 3'd7) ? 3'd6 : len_sel;

  // A length change blocks the handshake in the same cycle it is seen.
  assign len_change = (state != FLUSH) && (len_norm != len_q);
  assign in_ready   = (state != FLUSH) && !len_change;
  assign accept     = in_valid && in_ready;
  assign sr_en      = accept;
  assign sr_clr     = (state == FLUSH);

  // k = log2(N); last_cnt = N-1 is the fill count that completes the window.
  assign k         = (len_q == 3'd0) ? 4'd0 : ({1'b0, len_q} + 4'd2);
  assign last_cnt  = 8'((9'd1 << k) - 9'd1);
  assign fill_done = (cnt == last_cnt);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    tap_sel = '0;
    case (len_q)
      3'd1:    tap_sel = tap_8;
      3'd2:    tap_sel = tap_16;
      3'd3:    tap_sel = tap_32;
      3'd4:    tap_sel = tap_64;
      3'd5:    tap_sel = tap_128;
      3'd6:    tap_sel = tap_256;
      default: tap_sel = '0;
    endcase
  end

  // Taps are read before the delay line shifts, so tap_sel is the sample leaving the window.
  assign acc_next = acc + ACC_WIDTH'(x_in) - ACC_WIDTH'(tap_sel);

`ifdef MAVG_ROUND_EN
  assign rnd = (k == 4'd0) ? '0 : (ACC_WIDTH'(1) << (k - 4'd1));
`else
  assign rnd = '0;
`endif

  // Signed arithmetic shift: floor toward -inf. The sum of 256 full-scale
  // samples plus the rounding bias still fits ACC_WIDTH, so no saturation.
  assign y_full = (acc_next + rnd) >>> k;
  assign y_new  = (len_q == 3'd0) ? x_in : y_full[SIG_WIDTH-1:0];

  always_comb begin
    state_next = state;
    y_fire     = 1'b0;
    case (state)
      FLUSH: state_next = FILL;
      FILL: begin
        if (len_change) begin
          state_next = FLUSH;
        end else if (accept && fill_done) begin
          state_next = RUN;
          y_fire     = 1'b1;
        end
      end
      RUN: begin
        if (len_change) state_next = FLUSH;
        else            y_fire     = accept;
      end
      default: state_next = FLUSH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FLUSH;
      acc     <= '0;
      cnt     <= '0;
      len_q   <= '0;
      y_out   <= '0;
      y_valid <= 1'b0;
    end else begin
      state   <= state_next;
      y_valid <= y_fire;
      if (state == FLUSH) begin
        acc   <= '0;
        cnt   <= '0;
        len_q <= len_norm;
      end else if (accept) begin
        // Bypass never touches the running sum.
        acc   <= (len_q == 3'd0) ? '0 : acc_next;
        y_out <= y_new;
        if (state == FILL) cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mavg_sel.sv
// -----------------------------------------------------------------------------
// tb_mavg_sel -- self-checking bench for mavg_sel.
// Hosts a behavioural 256-deep delay line driven by sr_en/sr_clr, and a
// reference model that recomputes each output as the floor (or rounded) mean
// of the last N accepted samples since the last flush.
// Honours MAVG_ROUND_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_mavg_sel;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] x_in;
  logic        [2:0]  len_sel;
  logic signed [15:0] tap_8, tap_16, tap_32, tap_64, tap_128, tap_256;
  logic               sr_en, sr_clr;
  logic signed [15:0] y_out;
  logic               y_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mavg_sel dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .len_sel(len_sel),
    .tap_8(tap_8), .tap_16(tap_16), .tap_32(tap_32), .tap_64(tap_64),
    .tap_128(tap_128), .tap_256(tap_256),
    .sr_en(sr_en), .sr_clr(sr_clr), .y_out(y_out), .y_valid(y_valid)
  );

  // Delay line: dl[0] is the most recently accepted sample.
  logic signed [15:0] dl [256];
  always @(posedge clk) begin
    if (sr_clr) begin
      for (int i = 0; i < 256; i++) dl[i] <= '0;
    end else if (sr_en) begin
      for (int i = 255; i > 0; i--) dl[i] <= dl[i-1];
      dl[0] <= x_in;
    end
  end
  assign tap_8   = dl[7];
  assign tap_16  = dl[15];
  assign tap_32  = dl[31];
  assign tap_64  = dl[63];
  assign tap_128 = dl[127];
  assign tap_256 = dl[255];

  // Reference model state.
  bit      m_flush;
  int      m_len;
  int      hist[$];
  int      exp_y;
  bit      exp_yv;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int norm_len(input logic [2:0] l);
    return (l == 3'd7) ? 6 : int'(l);
  endfunction

  function automatic int len_n(input int l);
    return (l == 0) ? 1 : (1 << (l + 2));
  endfunction

  function automatic int fdiv(input int a, input int n);
    int q;
    q = a / n;
    if ((a % n != 0) && (a < 0)) q--;
    return q;
  endfunction

  // One clock cycle; entered and left just after a falling edge.
  task automatic cycle(input bit v, input int x, input logic [2:0] ls);
    bit acc_ok, exp_rdy;
    int n, sum;
    in_valid = v;
    x_in     = 16'(x);
    len_sel  = ls;
    #1;
    exp_rdy = !m_flush && (norm_len(ls) == m_len);
    acc_ok  = v && exp_rdy;
    check("sr_clr",   sr_clr,   m_flush);
    check("in_ready", in_ready, exp_rdy);
    check("sr_en",    sr_en,    acc_ok);
    exp_yv = 1'b0;
    if (m_flush) begin
      m_flush = 1'b0;
      m_len   = norm_len(ls);
      hist.delete();
    end else if (norm_len(ls) != m_len) begin
      m_flush = 1'b1;
    end else if (acc_ok) begin
      hist.push_front(x);
      if (hist.size() > 256) void'(hist.pop_back());
      n = len_n(m_len);
      if (n == 1) begin
        exp_y = x;
      end else begin
        sum = 0;
        for (int i = 0; i < n && i < hist.size(); i++) sum += hist[i];
`ifdef MAVG_ROUND_EN
        exp_y = fdiv(sum + n / 2, n);
`else
        exp_y = fdiv(sum, n);
`endif
      end
      exp_yv = (hist.size() >= n);
    end
    @(posedge clk);
    #1;
    check("y_valid", y_valid, exp_yv);
    check("y_out",   $signed(y_out), exp_y);
    @(negedge clk);
  endtask

  // Entered just after a falling edge; reset is asserted mid-cycle.
  task automatic apply_reset();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_y_out",   $signed(y_out), 0);
    check("rst_y_valid", y_valid, 0);
    check("rst_sr_clr",  sr_clr, 1);
    check("rst_ready",   in_ready, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    m_flush = 1'b1;
    exp_y   = 0;
    exp_yv  = 1'b0;
    hist.delete();
  endtask

  initial begin
    int yv_seen;
    int l;
    rst_n = 1'b0; in_valid = 1'b0; x_in = '0; len_sel = 3'd1;
    m_len = 0;
    @(negedge clk);
    apply_reset();

    // 1: N=8, eight samples of 100.
    for (int i = 0; i < 9; i++) cycle(i > 0, 100, 3'd1);
    check("t1_y_valid", y_valid, 1);
    check("t1_y_out", $signed(y_out), 100);

    // 2: window full of zeros, then a step to 800.
    for (int i = 0; i < 8; i++) cycle(1, 0, 3'd1);
    for (int i = 0; i < 8; i++) begin
      cycle(1, 800, 3'd1);
      check("t2_ramp", $signed(y_out), 100 * (i + 1));
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1, 800, 3'd1);
      check("t2_hold", $signed(y_out), 800);
    end

    // 3: change to N=32 with in_valid high; the change cycle refuses the sample.
    cycle(1, 7, 3'd3);
    cycle(1, 7, 3'd3);
    yv_seen = 0;
    for (int i = 0; i < 31; i++) begin
      cycle(1, 7, 3'd3);
      yv_seen += int'(y_valid);
    end
    check("t3_no_early", yv_seen, 0);
    cycle(1, 7, 3'd3);
    check("t3_first", y_valid, 1);

    // 4: N=8 window sums of +12 and -12.
    cycle(0, 0, 3'd1);
    cycle(0, 0, 3'd1);
    cycle(1, 12, 3'd1);
    for (int i = 0; i < 7; i++) cycle(1, 0, 3'd1);
`ifdef MAVG_ROUND_EN
    check("t4_pos", $signed(y_out), 2);
`else
    check("t4_pos", $signed(y_out), 1);
`endif
    cycle(1, -12, 3'd1);
    for (int i = 0; i < 7; i++) cycle(1, 0, 3'd1);
`ifdef MAVG_ROUND_EN
    check("t4_neg", $signed(y_out), -1);
`else
    check("t4_neg", $signed(y_out), -2);
`endif

    // 5: bypass, then codes 6 and 7 interchangeably.
    cycle(0, 0, 3'd0);
    cycle(0, 0, 3'd0);
    cycle(1, -5, 3'd0);
    check("t5_bypass_y", $signed(y_out), -5);
    check("t5_bypass_v", y_valid, 1);
    cycle(0, 0, 3'd6);
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(3) != 0, $signed(16'($urandom)), ($urandom_range(1) != 0) ? 3'd7 : 3'd6);

    // 6: reset in the middle of a gappy fill.
    cycle(0, 0, 3'd4);
    for (int i = 0; i < 30; i++) cycle($urandom_range(1) != 0, int'($urandom_range(2000)) - 1000, 3'd4);
    apply_reset();
    for (int i = 0; i < 20; i++) cycle($urandom_range(1) != 0, int'($urandom_range(2000)) - 1000, 3'd4);

    // Random soak: full-scale data, occasional length changes.
    l = 2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) l = $urandom_range(7);
      cycle($urandom_range(4) != 0, $signed(16'($urandom)), 3'(l));
    end

    // Extremes at N=256 to exercise the full accumulator range.
    cycle(0, 0, 3'd6);
    for (int i = 0; i < 300; i++) cycle(1, -32768, 3'd6);
    check("max_neg", $signed(y_out), -32768);
    for (int i = 0; i < 300; i++) cycle(1, 32767, 3'd6);
    check("max_pos", $signed(y_out), 32767);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
